// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch unit bundle: EX redirect, IMEM request/response, IF/ID handshake
interface fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 4
);
  logic                      redirect_i;
  logic [DATA_WIDTH-1:0]     redirect_pc_i;
  logic                      imem_req_o;
  logic [ADDR_WIDTH-1:0]     imem_addr_o;
  logic [DATA_WIDTH-1:0]     imem_rdata_i;
  logic                      id_ready_i;
  logic                      id_valid_o;
  logic [DATA_WIDTH-1:0]     id_pc_o;
  logic [DATA_WIDTH-1:0]     id_inst_o;
  logic [$clog2(DEPTH):0]    count_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_rdata_i, id_ready_i,
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_rdata_i, id_ready_i,
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, inst} entries with flush and combinational head
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, IMEM request credit, in-flight tag and redirect flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input logic      clk_i,
  input logic      rst_i,
  fetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] tag_pc;
  logic [DATA_WIDTH-1:0] target_pc;
  logic [DATA_WIDTH-1:0] req_pc;
  logic                  inflight;
  logic                  credit;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  fetch_entry_t          head;
  fetch_entry_t          push_entry;

  assign target_pc = bus.redirect_pc_i & ~DATA_WIDTH'(3);
  assign req_pc    = bus.redirect_i ? target_pc : fetch_pc;

  // Credit counts only current occupancy plus the outstanding word; same-cycle pops are ignored.
  assign credit = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
  assign issue  = bus.redirect_i || credit;

  assign push       = inflight && !bus.redirect_i && !full;
  assign pop        = bus.id_valid_o && bus.id_ready_i;
  assign push_entry = '{pc: tag_pc, inst: bus.imem_rdata_i};

  assign bus.imem_req_o  = issue && !rst_i;
  assign bus.imem_addr_o = req_pc[ADDR_WIDTH-1:0];
  assign bus.id_valid_o  = !empty && !bus.redirect_i;
  assign bus.id_pc_o     = head.pc;
  assign bus.id_inst_o   = head.inst;
  assign bus.count_o     = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_pc   <= req_pc;
        fetch_pc <= req_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_i),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against an expected-PC-stream model
module tb_fetch_unit;
  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

  fetch_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // IMEM content: each word holds its own byte address.
  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {19'b0, pc[12:0]};
  endfunction

  // After reset or a redirect the delivered stream is target, target+4, ... (32-bit wrap).
  task automatic start_stream(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back((pc & ~32'd3) + 32'(4 * i));
  endtask

  always @(posedge clk)
    bus.imem_rdata_i <= bus.imem_req_o ? {19'b0, bus.imem_addr_o} : 32'hDEAD_BEEF;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst) begin
      if (bus.imem_req_o) check("addr_align", {30'b0, bus.imem_addr_o[1:0]}, 32'd0);
      if (bus.id_valid_o && bus.id_ready_i) begin
        delivered++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got pc %h want no delivery", bus.id_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", bus.id_pc_o, e);
          check("sb_inst", bus.id_inst_o, word_of(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    tick();
    rst = 1'b0;
    start_stream(32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int since;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.id_ready_i    = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    check("rst_valid", {31'b0, bus.id_valid_o}, 32'd0);
    check("rst_count", {29'b0, bus.count_o}, 32'd0);
    check("rst_pc", bus.id_pc_o, 32'd0);
    check("rst_inst", bus.id_inst_o, 32'd0);

    // 1: streaming with ready high
    release_reset();
    @(negedge clk);
    check("t1_req", {31'b0, bus.imem_req_o}, 32'd1);
    check("t1_valid_c0", {31'b0, bus.id_valid_o}, 32'd0);
    @(negedge clk);
    check("t1_valid_c1", {31'b0, bus.id_valid_o}, 32'd0);
    @(negedge clk);
    check("t1_valid_c2", {31'b0, bus.id_valid_o}, 32'd1);
    check("t1_first_pc", bus.id_pc_o, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t1_sustain", {31'b0, bus.id_valid_o}, 32'd1);
      check("t1_count_le2", {31'b0, (bus.count_o <= 3'd2)}, 32'd1);
    end

    // 2: backpressure from cycle 0
    tick();
    rst = 1'b1;
    bus.id_ready_i = 1'b0;
    release_reset();
    repeat (12) @(negedge clk);
    check("t2_count_full", {29'b0, bus.count_o}, 32'd4);
    check("t2_req_off", {31'b0, bus.imem_req_o}, 32'd0);
    check("t2_head_pc", bus.id_pc_o, 32'd0);
    check("t2_valid", {31'b0, bus.id_valid_o}, 32'd1);
    tick();
    bus.id_ready_i = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_no_gap", {31'b0, bus.id_valid_o}, 32'd1);
    end
    tick();
    check("t2_delivered", {31'b0, (delivered - d0 >= 6)}, 32'd1);

    // 3: redirect with three buffered entries and one in flight
    rst = 1'b1;
    bus.id_ready_i = 1'b0;
    release_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.count_o == 3'd3) break;
    end
    check("t3_reach3", {29'b0, bus.count_o}, 32'd3);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    bus.id_ready_i    = 1'b1;
    start_stream(32'h100);
    @(negedge clk);
    check("t3_valid_r0", {31'b0, bus.id_valid_o}, 32'd0);
    check("t3_req_r0", {31'b0, bus.imem_req_o}, 32'd1);
    check("t3_addr_r0", {19'b0, bus.imem_addr_o}, 32'h100);
    tick();
    bus.redirect_i = 1'b0;
    @(negedge clk);
    check("t3_valid_r1", {31'b0, bus.id_valid_o}, 32'd0);
    @(negedge clk);
    check("t3_valid_r2", {31'b0, bus.id_valid_o}, 32'd1);
    check("t3_pc_r2", bus.id_pc_o, 32'h100);
    repeat (4) @(negedge clk);

    // 4: misaligned redirect target
    tick();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h102;
    start_stream(32'h102);
    @(negedge clk);
    check("t4_addr", {19'b0, bus.imem_addr_o}, 32'h100);
    tick();
    bus.redirect_i = 1'b0;
    repeat (6) @(negedge clk);

    // 5: back-to-back redirects, then a target that wraps past 2^32
    tick();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h40;
    start_stream(32'h40);
    tick();
    bus.redirect_pc_i = 32'h80;
    start_stream(32'h80);
    tick();
    bus.redirect_i = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_pc", bus.id_pc_o, 32'h80);
    repeat (4) @(negedge clk);
    tick();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    start_stream(32'hFFFF_FFF8);
    tick();
    bus.redirect_i = 1'b0;
    repeat (8) @(negedge clk);

    // 6: asynchronous reset mid-stream
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", {31'b0, bus.id_valid_o}, 32'd0);
    check("t6_count", {29'b0, bus.count_o}, 32'd0);
    check("t6_req", {31'b0, bus.imem_req_o}, 32'd0);
    tick();
    release_reset();
    repeat (3) @(negedge clk);
    check("t6_restart_valid", {31'b0, bus.id_valid_o}, 32'd1);
    check("t6_restart_pc", bus.id_pc_o, 32'd0);

    // Random ready and redirects
    d0    = delivered;
    since = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      bus.id_ready_i = ($urandom_range(0, 3) != 0);
      since++;
      if ($urandom_range(0, 19) == 0 || since > 100) begin
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = $urandom;
        start_stream(bus.redirect_pc_i);
        since = 0;
      end else begin
        bus.redirect_i = 1'b0;
      end
    end
    tick();
    bus.redirect_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rand_progress", {31'b0, (delivered - d0 > 100)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
